ripple_carry_adder_32: RTL and testbench

- 32-bit ripple-carry adder computing in1 + in2 + cin as a 33-bit result (sum plus carry-out).
- Arithmetic datapath is purely combinational: a chain of 32 one-bit full-adder cells, with the carry rippling from bit 0 to bit 31.
- A registered copy of the result and a signed-overflow flag is provided for synchronous consumers.
- Used as the baseline adder in the adder-comparison datapath.

---
 rtl/ripple_carry_adder_32.sv | 68 ++++++
 tb/tb_ripple_carry_adder_32.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder_32.sv
// rtl/ripple_carry_adder_32.sv - 32-bit ripple-carry adder with registered sum, carry and signed overflow

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module ripple_carry_adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  assign w_carry[0] = cin;

  // Carry must ripple cell to cell; no lookahead shortcuts.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_fa (
      .i_a (in1[i]),
      .i_b (in2[i]),
      .i_c (w_carry[i]),
      .o_s (w_sum[i]),
      .o_c (w_carry[i+1])
    );
  end

  assign sum  = w_sum;
  assign cout = w_carry[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_carry[WIDTH];
      r_ovf  <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
    end
  end

  assign sum_q  = r_sum;
  assign cout_q = r_cout;
  assign ovf_q  = r_ovf;
endmodule

// File: tb/tb_ripple_carry_adder_32.sv
// tb/tb_ripple_carry_adder_32.sv - self-checking bench for ripple_carry_adder_32 against an arithmetic model

module tb_ripple_carry_adder_32;
  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        ovf_q;

  int checks = 0;
  int errors = 0;

  ripple_carry_adder_32 dut (
    .clk    (clk),
    .rst    (rst),
    .in1    (in1),
    .in2    (in2),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] model_sum(input logic [31:0] a, input logic [31:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  // Signed overflow: the true signed result falls outside the 32-bit two's complement range.
  function automatic logic model_ovf(input logic [31:0] a, input logic [31:0] b, input logic c);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at negedge, check combinational outputs 2 ns later, then registered outputs 1 ns after the next posedge.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [32:0] exp33, input logic exp_ovf);
    @(negedge clk);
    in1 = a;
    in2 = b;
    cin = c;
    #2;
    chk({tag, "_comb"}, {31'd0, cout, sum}, {31'd0, exp33});
    @(posedge clk);
    #1;
    chk({tag, "_reg"}, {30'd0, ovf_q, cout_q, sum_q}, {30'd0, exp_ovf, exp33});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        c;

    rst = 1'b1;
    in1 = 32'h0;
    in2 = 32'h0;
    cin = 1'b0;
    #1;
    chk("reset_regs", {30'd0, ovf_q, cout_q, sum_q}, 64'd0);
    chk("reset_comb", {31'd0, cout, sum}, 64'd0);

    @(negedge clk);
    rst = 1'b0;

    step("zero",        32'h00000000, 32'h00000000, 1'b0, 33'h000000000, 1'b0);
    step("small_cin",   32'h00000001, 32'h00000001, 1'b1, 33'h000000003, 1'b0);
    step("wrap",        32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h100000000, 1'b0);
    step("wrap_cin",    32'hFFFFFFFF, 32'h00000001, 1'b1, 33'h100000001, 1'b0);
    step("max",         32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1FFFFFFFE, 1'b0);
    step("max_cin",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1FFFFFFFF, 1'b0);
    step("ripple",      32'hAAAAAAAA, 32'h55555555, 1'b0, 33'h0FFFFFFFF, 1'b0);
    step("ripple_cin",  32'hAAAAAAAA, 32'h55555555, 1'b1, 33'h100000000, 1'b0);
    step("zero_cin",    32'h00000000, 32'h00000000, 1'b1, 33'h000000001, 1'b0);
    step("neg_ovf",     32'h80000000, 32'h80000000, 1'b0, 33'h100000000, 1'b1);

    // Asynchronous reset between edges while registers hold a nonzero value.
    @(negedge clk);
    in1 = 32'h12345678;
    in2 = 32'h00000001;
    cin = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_regs", {30'd0, ovf_q, cout_q, sum_q}, 64'd0);
    chk("async_rst_comb", {31'd0, cout, sum}, 64'h12345679);
    @(posedge clk);
    #1;
    chk("rst_hold_regs", {30'd0, ovf_q, cout_q, sum_q}, 64'd0);
    in1 = 32'h0000000F;
    #2;
    chk("rst_comb_track", {31'd0, cout, sum}, 64'h10);

    @(negedge clk);
    rst = 1'b0;
    step("pos_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 33'h080000000, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = $urandom;
      c = 1'($urandom_range(0, 1));
      if (i % 8 == 0) a = {a[31], 31'h7FFFFFFF};
      step("rand", a, b, c, model_sum(a, b, c), model_ovf(a, b, c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
